// File: rtl/spi_pkg.sv
// Shared types and defaults for the oversampled SPI slave.
package spi_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StActive
    } spi_state_e;

    localparam int unsigned SyncStagesDefault = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with rise/fall detection on the synchronised level.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int unsigned Stages   = SyncStagesDefault,
    parameter bit          ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [Stages-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {Stages{ResetVal}};
            prev_q <= ResetVal;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
            prev_q <= sync_q[Stages-1];
        end
    end

    assign q_o    = sync_q[Stages-1];
    assign rise_o = sync_q[Stages-1] & ~prev_q;
    assign fall_o = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/spi_slave_sync.sv
// Fully synchronous full-duplex SPI slave, all four modes, with a one-word tx holding buffer.
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter bit          MSB_FIRST   = 1'b1,
    parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_err
);

    localparam int unsigned   CntW    = $clog2(DATA_W);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic cs_level_unused, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(CPOL)) u_sync_sclk (
        .clk_i  (clk),
        .rst_i  (rst),
        .d_i    (sclk),
        .q_o    (sclk_level_unused),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_cs (
        .clk_i  (clk),
        .rst_i  (rst),
        .d_i    (cs),
        .q_o    (cs_level_unused),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_mosi (
        .clk_i  (clk),
        .rst_i  (rst),
        .d_i    (mosi),
        .q_o    (mosi_s),
        .rise_o (mosi_rise_unused),
        .fall_o (mosi_fall_unused)
    );

    logic lead_edge, trail_edge, sample_edge, shift_edge;

    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    spi_state_e        state_q, state_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [DATA_W-1:0] hold_q;
    logic              hold_full_q;
    logic              rx_valid_q, rx_valid_d;
    logic              underrun_q;
    logic              frame_err_q, frame_err_d;
    logic              load_tx;

    // A drain frees the buffer in the same cycle so a new word can be accepted immediately.
    assign tx_ready = ~hold_full_q | load_tx;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        load_tx     = 1'b0;
        case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d   = StActive;
                    bit_cnt_d = '0;
                    load_tx   = ~CPHA;
                end
            end
            StActive: begin
                if (cs_rise) begin
                    state_d     = StIdle;
                    frame_err_d = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                    rx_shift_d  = '0;
                end else if (sample_edge) begin
                    rx_shift_d = MSB_FIRST ? {rx_shift_q[DATA_W-2:0], mosi_s}
                                           : {mosi_s, rx_shift_q[DATA_W-1:1]};
                    if (bit_cnt_q == LastBit) begin
                        rx_data_d  = rx_shift_d;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (shift_edge) begin
                    // bit_cnt==0 on a shift edge always marks a word boundary in either phase
                    if (bit_cnt_q == '0) begin
                        load_tx = 1'b1;
                    end else begin
                        tx_shift_d = MSB_FIRST ? {tx_shift_q[DATA_W-2:0], 1'b0}
                                               : {1'b0, tx_shift_q[DATA_W-1:1]};
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (load_tx) begin
            tx_shift_d = hold_full_q ? hold_q : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= load_tx & ~hold_full_q;
            frame_err_q <= frame_err_d;
            if (tx_valid && tx_ready) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end else if (load_tx) begin
                hold_full_q <= 1'b0;
            end
        end
    end

    assign miso        = MSB_FIRST ? tx_shift_q[DATA_W-1] : tx_shift_q[0];
    assign miso_oe     = (state_q == StActive);
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Five DUT instances (modes 0-3 MSB-first, mode 0 LSB-first) driven by a bit-banged SPI master.
module tb_spi_slave_sync;

    localparam int N = 5;
    localparam int H = 8;  // sclk half period in clk cycles
    localparam bit [N-1:0] CPOL_V = 5'b01100;
    localparam bit [N-1:0] CPHA_V = 5'b01010;
    localparam bit [N-1:0] MSB_V  = 5'b01111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mosi;
    logic [N-1:0] sclk, cs, miso, miso_oe, tx_valid, tx_ready, rx_valid, tx_underrun, frame_err;
    logic [7:0] tx_data [N];
    logic [7:0] rx_data [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        spi_slave_sync #(
            .DATA_W      (8),
            .CPOL        (CPOL_V[g]),
            .CPHA        (CPHA_V[g]),
            .MSB_FIRST   (MSB_V[g]),
            .SYNC_STAGES (2)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .sclk        (sclk[g]),
            .cs          (cs[g]),
            .mosi        (mosi),
            .miso        (miso[g]),
            .miso_oe     (miso_oe[g]),
            .tx_data     (tx_data[g]),
            .tx_valid    (tx_valid[g]),
            .tx_ready    (tx_ready[g]),
            .rx_data     (rx_data[g]),
            .rx_valid    (rx_valid[g]),
            .tx_underrun (tx_underrun[g]),
            .frame_err   (frame_err[g])
        );
    end

    typedef struct packed {
        int unsigned dut;
        logic [7:0]  data;
    } rx_item_t;

    rx_item_t exp_q[$];
    rx_item_t got_q[$];
    int rxv_cnt [N];
    int und_cnt [N];
    int ferr_cnt [N];
    int checks = 0;
    int fails = 0;

    // Monitor: collect received words and count status pulses
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rx_valid[k] === 1'b1) begin
                got_q.push_back('{dut: k, data: rx_data[k]});
                rxv_cnt[k]++;
            end
            if (tx_underrun[k] === 1'b1) und_cnt[k]++;
            if (frame_err[k] === 1'b1) ferr_cnt[k]++;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int d, input logic [7:0] w);
        exp_q.push_back('{dut: d, data: w});
    endtask

    task automatic pop_rx(output rx_item_t e, output rx_item_t g);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '{dut: 98, data: 8'h00};
        g = (got_q.size() > 0) ? got_q.pop_front() : '{dut: 99, data: 8'h00};
    endtask

    task automatic load_tx(input int d, input logic [7:0] w);
        bit done;
        done = 1'b0;
        @(negedge clk);
        tx_data[d]  = w;
        tx_valid[d] = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (tx_ready[d]) done = 1'b1;
            @(negedge clk);
        end
        tx_valid[d] = 1'b0;
        checks++;
        if (!done || tx_ready[d] !== 1'b0) begin
            fails++;
            $display("FAIL load_tx dut%0d: accepted=%0b tx_ready=%b, required accepted=1 tx_ready=0",
                     d, done, tx_ready[d]);
        end
    endtask

    task automatic cs_low(input int d);
        @(negedge clk);
        cs[d] = 1'b0;
    endtask

    task automatic cs_high(input int d);
        wait_clks(H);
        cs[d] = 1'b1;
        wait_clks(2 * H);
    endtask

    task automatic shift_word(input int d, input logic [7:0] w, input int nbits,
                              output logic [7:0] m);
        int idx;
        m = '0;
        for (int i = 0; i < nbits; i++) begin
            idx = MSB_V[d] ? 7 - i : i;
            if (!CPHA_V[d]) mosi = w[idx];
            wait_clks(H);
            sclk[d] = ~CPOL_V[d];
            if (!CPHA_V[d]) m[idx] = miso[d];
            else mosi = w[idx];
            wait_clks(H);
            sclk[d] = CPOL_V[d];
            if (CPHA_V[d]) m[idx] = miso[d];
        end
    endtask

    task automatic xfer(input int d, input logic [7:0] w, output logic [7:0] m);
        cs_low(d);
        shift_word(d, w, 8, m);
        cs_high(d);
    endtask

    task automatic test_reset();
        wait_clks(3);
        for (int k = 0; k < N; k++) begin
            checks++;
            if ({miso[k], miso_oe[k], tx_ready[k], rx_valid[k], tx_underrun[k], frame_err[k]}
                !== 6'b001000) begin
                fails++;
                $display("FAIL reset_flags dut%0d: got %b%b%b%b%b%b required 001000", k, miso[k],
                         miso_oe[k], tx_ready[k], rx_valid[k], tx_underrun[k], frame_err[k]);
            end
            checks++;
            if (rx_data[k] !== 8'h00) begin
                fails++;
                $display("FAIL reset_rx_data dut%0d: got %h required 00", k, rx_data[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        wait_clks(H);
    endtask

    task automatic test_mode0();
        logic [7:0] m;
        rx_item_t e, g;
        int r;
        r = rxv_cnt[0];
        load_tx(0, 8'hA5);
        push_exp(0, 8'h3C);
        xfer(0, 8'h3C, m);
        checks++;
        if (m !== 8'hA5) begin
            fails++;
            $display("FAIL mode0_miso: got %h required a5", m);
        end
        pop_rx(e, g);
        checks++;
        if (g !== e) begin
            fails++;
            $display("FAIL mode0_rx: got dut%0d %h required dut%0d %h", g.dut, g.data, e.dut, e.data);
        end
        checks++;
        if (rxv_cnt[0] - r != 1) begin
            fails++;
            $display("FAIL mode0_rx_valid_pulses: got %0d required 1", rxv_cnt[0] - r);
        end
        checks++;
        if (tx_ready[0] !== 1'b1 || miso_oe[0] !== 1'b0) begin
            fails++;
            $display("FAIL mode0_idle: tx_ready=%b miso_oe=%b required 1 0", tx_ready[0], miso_oe[0]);
        end
    endtask

    task automatic test_modes();
        logic [7:0] m;
        rx_item_t e, g;
        for (int d = 1; d <= 3; d++) begin
            load_tx(d, 8'h7E);
            push_exp(d, 8'h81);
            xfer(d, 8'h81, m);
            checks++;
            if (m !== 8'h7E) begin
                fails++;
                $display("FAIL mode%0d_miso: got %h required 7e", d, m);
            end
            pop_rx(e, g);
            checks++;
            if (g !== e) begin
                fails++;
                $display("FAIL mode%0d_rx: got dut%0d %h required dut%0d %h", d, g.dut, g.data,
                         e.dut, e.data);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m1, m2;
        rx_item_t e, g;
        int u, r;
        u = und_cnt[1];
        r = rxv_cnt[1];
        load_tx(1, 8'hC9);
        cs_low(1);
        push_exp(1, 8'h12);
        shift_word(1, 8'h12, 8, m1);
        load_tx(1, 8'h5A);
        push_exp(1, 8'h34);
        shift_word(1, 8'h34, 8, m2);
        checks++;
        if (miso_oe[1] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_miso_oe: got %b required 1", miso_oe[1]);
        end
        cs_high(1);
        checks++;
        if (m1 !== 8'hC9 || m2 !== 8'h5A) begin
            fails++;
            $display("FAIL b2b_miso: got %h %h required c9 5a", m1, m2);
        end
        for (int i = 0; i < 2; i++) begin
            pop_rx(e, g);
            checks++;
            if (g !== e) begin
                fails++;
                $display("FAIL b2b_rx%0d: got dut%0d %h required dut%0d %h", i, g.dut, g.data,
                         e.dut, e.data);
            end
        end
        checks++;
        if (und_cnt[1] != u || rxv_cnt[1] - r != 2) begin
            fails++;
            $display("FAIL b2b_counts: underruns=%0d rx_valids=%0d required 0 2", und_cnt[1] - u,
                     rxv_cnt[1] - r);
        end
    endtask

    task automatic test_frame_err();
        logic [7:0] m;
        rx_item_t e, g;
        int r, f;
        r = rxv_cnt[0];
        f = ferr_cnt[0];
        cs_low(0);
        shift_word(0, 8'hFF, 5, m);
        cs_high(0);
        checks++;
        if (ferr_cnt[0] - f != 1 || rxv_cnt[0] != r) begin
            fails++;
            $display("FAIL frame_err_pulses: frame_err=%0d rx_valid=%0d required 1 0",
                     ferr_cnt[0] - f, rxv_cnt[0] - r);
        end
        checks++;
        if (rx_data[0] !== 8'h3C) begin
            fails++;
            $display("FAIL frame_err_rx_hold: got %h required 3c", rx_data[0]);
        end
        load_tx(0, 8'h66);
        push_exp(0, 8'h55);
        xfer(0, 8'h55, m);
        checks++;
        if (m !== 8'h66) begin
            fails++;
            $display("FAIL after_err_miso: got %h required 66", m);
        end
        pop_rx(e, g);
        checks++;
        if (g !== e) begin
            fails++;
            $display("FAIL after_err_rx: got dut%0d %h required dut%0d %h", g.dut, g.data, e.dut,
                     e.data);
        end
    endtask

    task automatic test_underrun_lsb();
        logic [7:0] m;
        rx_item_t e, g;
        int u;
        u = und_cnt[0];
        push_exp(0, 8'h96);
        xfer(0, 8'h96, m);
        checks++;
        if (und_cnt[0] == u || m !== 8'h00) begin
            fails++;
            $display("FAIL underrun: pulses=%0d miso=%h required >0 00", und_cnt[0] - u, m);
        end
        pop_rx(e, g);
        checks++;
        if (g !== e) begin
            fails++;
            $display("FAIL underrun_rx: got dut%0d %h required dut%0d %h", g.dut, g.data, e.dut,
                     e.data);
        end
        load_tx(4, 8'hB4);
        push_exp(4, 8'h01);
        xfer(4, 8'h01, m);
        checks++;
        if (m !== 8'hB4) begin
            fails++;
            $display("FAIL lsb_miso: got %h required b4", m);
        end
        pop_rx(e, g);
        checks++;
        if (g !== e || rx_data[4] !== 8'h01) begin
            fails++;
            $display("FAIL lsb_rx: got dut%0d %h required dut%0d %h", g.dut, g.data, e.dut, e.data);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] m;
        rx_item_t e, g;
        int f;
        f = ferr_cnt[2];
        load_tx(2, 8'h11);
        cs_low(2);
        shift_word(2, 8'hF0, 4, m);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({miso[2], miso_oe[2], tx_ready[2], rx_valid[2], tx_underrun[2], frame_err[2]}
            !== 6'b001000 || rx_data[2] !== 8'h00) begin
            fails++;
            $display("FAIL mid_reset: flags %b%b%b%b%b%b rx_data %h required 001000 00", miso[2],
                     miso_oe[2], tx_ready[2], rx_valid[2], tx_underrun[2], frame_err[2], rx_data[2]);
        end
        cs[2]   = 1'b1;
        sclk[2] = CPOL_V[2];
        mosi    = 1'b0;
        wait_clks(4);
        rst = 1'b0;
        wait_clks(H);
        load_tx(2, 8'h3D);
        push_exp(2, 8'hC3);
        xfer(2, 8'hC3, m);
        checks++;
        if (m !== 8'h3D) begin
            fails++;
            $display("FAIL post_reset_miso: got %h required 3d", m);
        end
        pop_rx(e, g);
        checks++;
        if (g !== e || ferr_cnt[2] != f) begin
            fails++;
            $display("FAIL post_reset_rx: got dut%0d %h frame_errs %0d required dut%0d %h 0", g.dut,
                     g.data, ferr_cnt[2] - f, e.dut, e.data);
        end
    endtask

    initial begin
        sclk     = CPOL_V;
        cs       = '1;
        mosi     = 1'b0;
        tx_valid = '0;
        for (int k = 0; k < N; k++) tx_data[k] = 8'h00;
        test_reset();
        test_mode0();
        test_modes();
        test_back_to_back();
        test_frame_err();
        test_underrun_lsb();
        test_reset_mid();
        checks++;
        if (got_q.size() != 0) begin
            fails++;
            $display("FAIL stray_rx_words: got %0d extra required 0", got_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

endmodule
